// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: default 640x480 timing, derived totals and FSM state codes
// shared by the VGA receive-side decoder.
package vga_rx_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam bit SYNC_ACTIVE_LOW = 1'b1;

    // Width of every line/column counter and coordinate output.
    localparam int CNT_W = 10;

    typedef logic [1:0] state_t;
    localparam state_t SEARCH = 2'd0;
    localparam state_t CHECK  = 2'd1;
    localparam state_t LOCKED = 2'd2;

endpackage

// File: rtl/vga_rx_sync_edge.sv
// vga_rx_sync_edge: registers one sync pin, normalises it to active-high and
// flags the first sample at which it becomes active.
module vga_rx_sync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_pin,
    output logic lead
);

    logic active;
    logic prev;

    // Input flop plus one-sample history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            prev   <= 1'b0;
        end else begin
            active <= sync_pin ^ ACTIVE_LOW;
            prev   <= active;
        end
    end

    assign lead = active & ~prev;

endmodule

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: locks to incoming VGA timing, recovers pixel coordinates and
// colour, and verifies line length and lines per frame.
// Optional feature: define VGA_RX_SUM_EN to add the per-frame rgb checksum on
// frame_sum/sum_valid; otherwise both outputs are tied to zero.
module vga_rx_decoder #(
    parameter int H_VISIBLE       = vga_rx_pkg::H_VISIBLE,
    parameter int H_FP            = vga_rx_pkg::H_FP,
    parameter int H_SYNC          = vga_rx_pkg::H_SYNC,
    parameter int H_BP            = vga_rx_pkg::H_BP,
    parameter int V_VISIBLE       = vga_rx_pkg::V_VISIBLE,
    parameter int V_FP            = vga_rx_pkg::V_FP,
    parameter int V_SYNC          = vga_rx_pkg::V_SYNC,
    parameter int V_BP            = vga_rx_pkg::V_BP,
    parameter bit SYNC_ACTIVE_LOW = vga_rx_pkg::SYNC_ACTIVE_LOW
) (
    input  logic        clk_main,
    input  logic        rst,
    input  logic        red_i,
    input  logic        green_i,
    input  logic        blue_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] frame_sum,
    output logic        sum_valid
);
    import vga_rx_pkg::*;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_TOT   = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_TOT   = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BP + H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BP + V_VISIBLE - 1);

    logic [2:0]       rgb_s1;
    logic             hs_lead, vs_lead;
    logic [CNT_W-1:0] hcnt, vcnt, lcnt;
    logic [CNT_W-1:0] hcnt_cur, vcnt_cur;
    logic             vpend, first, bad;
    state_t           state, state_next;
    logic             h_sat, line_err, frame_err, viol, vis, lock_n;

    vga_rx_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs (
        .clk(clk_main), .rst(rst), .sync_pin(hsync_i), .lead(hs_lead)
    );

    vga_rx_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs (
        .clk(clk_main), .rst(rst), .sync_pin(vsync_i), .lead(vs_lead)
    );

    // Stage 1 colour flop, aligned with the sync flops inside the edge detectors.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) rgb_s1 <= '0;
        else     rgb_s1 <= {red_i, green_i, blue_i};
    end

    // Position of the stage-1 sample, violation detection and next FSM state.
    always_comb begin
        hcnt_cur = hcnt;
        if (hs_lead)             hcnt_cur = '0;
        else if (hcnt != H_TOT)  hcnt_cur = hcnt + 1'b1;

        vcnt_cur = vcnt;
        if (hs_lead) vcnt_cur = (vpend | vs_lead) ? '0 : vcnt + 1'b1;

        // A line that runs past its nominal length is flagged once, as it saturates.
        h_sat     = !hs_lead && (hcnt == H_LAST);
        line_err  = hs_lead && (hcnt != H_LAST) && !first;
        frame_err = vs_lead && (lcnt != V_TOT);
        viol      = h_sat | line_err | frame_err;

        vis = (hcnt_cur >= H_START) && (hcnt_cur <= H_END) &&
              (vcnt_cur >= V_START) && (vcnt_cur <= V_END);

        state_next = state;
        case (state)
            SEARCH:  if (vs_lead) state_next = CHECK;
            CHECK:   if (vs_lead && !bad && !viol) state_next = LOCKED;
            LOCKED:  if (viol) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
        lock_n = (state_next == LOCKED);
    end

    // Counters, vsync pending flag, measurement bookkeeping and FSM state.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            hcnt  <= '0;
            vcnt  <= '0;
            lcnt  <= '0;
            vpend <= 1'b0;
            first <= 1'b1;
            bad   <= 1'b0;
            state <= SEARCH;
        end else begin
            hcnt  <= hcnt_cur;
            vcnt  <= vcnt_cur;
            state <= state_next;

            if (hs_lead)      vpend <= 1'b0;
            else if (vs_lead) vpend <= 1'b1;

            // Lines per frame: a coincident hsync edge belongs to the new frame.
            if (vs_lead)                  lcnt <= hs_lead ? CNT_W'(1) : '0;
            else if (hs_lead && lcnt != '1) lcnt <= lcnt + 1'b1;

            // Line length is only meaningful once an hsync edge has set hcnt.
            if (state == LOCKED && viol) first <= 1'b1;
            else if (hs_lead)            first <= 1'b0;

            // Any violation during a CHECK frame spoils that measurement.
            if (state == CHECK && !vs_lead) bad <= bad | viol;
            else                            bad <= 1'b0;
        end
    end

    // Stage 2: registered pixel, lock and error outputs.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            pix_valid   <= vis && lock_n;
            pix_x       <= vis ? hcnt_cur - H_START : '0;
            pix_y       <= vis ? vcnt_cur - V_START : '0;
            pix_rgb     <= vis ? rgb_s1 : '0;
            frame_start <= vis && lock_n && (hcnt_cur == H_START) && (vcnt_cur == V_START);
            locked      <= lock_n;
            timing_err  <= viol && (state != SEARCH);
        end
    end

`ifdef VGA_RX_SUM_EN
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_VISIBLE - 1);

    logic [15:0] acc;

    // Frame checksum: restart at pixel (0,0), publish after the last pixel.
    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            frame_sum <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (pix_valid) begin
                acc <= frame_start ? {13'd0, pix_rgb} : acc + {13'd0, pix_rgb};
                if (pix_x == X_LAST && pix_y == Y_LAST) begin
                    frame_sum <= acc + {13'd0, pix_rgb};
                    sum_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign frame_sum = '0;
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb_vga_rx_decoder: drives a reduced-geometry VGA stream with random colours
// and checks lock behaviour, recovered pixels and the optional checksum
// against a raster-order picture model.
module tb_vga_rx_decoder;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
    localparam int NPIX = HV * VV;
`ifdef VGA_RX_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic clk_main = 1'b0;
    logic rst = 1'b0;
    logic red_i = 1'b0, green_i = 1'b0, blue_i = 1'b0;
    logic hsync_i = 1'b1, vsync_i = 1'b1;
    logic        pix_valid, frame_start, locked, timing_err, sum_valid;
    logic [9:0]  pix_x, pix_y;
    logic [2:0]  pix_rgb;
    logic [15:0] frame_sum;

    vga_rx_decoder #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_main(clk_main), .rst(rst),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .frame_sum(frame_sum), .sum_valid(sum_valid)
    );

    always #5 clk_main = ~clk_main;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] rgb;
    } pix_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] img [0:VV-1][0:HV-1];

    // Observation log written only by the monitor.
    pix_t        obs_q[$];
    int          terr_cnt = 0, fs_cnt = 0, sv_cnt = 0;
    pix_t        fs_pix = '0;
    logic        fs_pv = 1'b0;
    logic        terr_locked = 1'b0;
    logic [15:0] last_sum = '0;

    always @(negedge clk_main) begin
        if (pix_valid) obs_q.push_back({pix_x, pix_y, pix_rgb});
        if (frame_start) begin
            fs_cnt++;
            fs_pix = {pix_x, pix_y, pix_rgb};
            fs_pv  = pix_valid;
        end
        if (timing_err) begin
            terr_cnt++;
            terr_locked = locked;
        end
        if (sum_valid) begin
            sv_cnt++;
            last_sum = frame_sum;
        end
    end

    // Picture model: number of logged pixels from 'start' that differ from
    // the k-th pixel of the current picture in raster order.
    function automatic int pix_errors(input int start, input int n);
        int   e;
        pix_t p;
        e = 0;
        for (int k = 0; k < n; k++) begin
            if (start + k >= obs_q.size()) e++;
            else begin
                p = obs_q[start + k];
                if (p.x != 10'(k % HV) || p.y != 10'(k / HV) || p.rgb != img[k / HV][k % HV]) e++;
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] img_sum();
        logic [15:0] s;
        s = '0;
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++) s = s + 16'(img[y][x]);
        return SUM_EN ? s : 16'h0;
    endfunction

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_main); #1;
            hsync_i = 1'b1; vsync_i = 1'b1;
            {red_i, green_i, blue_i} = 3'b000;
        end
    endtask

    // One transmitted frame. mode 0 white, 1 black, else random colours.
    // short_row loses its last clock; rst pulses for 3 clocks mid rst_row.
    task automatic send_frame(input int nlines, input int short_row, input int mode, input int rst_row);
        int len;
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++)
                img[y][x] = (mode == 0) ? 3'b111 : (mode == 1) ? 3'b000 : 3'($urandom_range(0, 7));
        for (int v = 0; v < nlines; v++) begin
            len = (v == short_row) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                @(posedge clk_main); #1;
                hsync_i = !(h < HS);
                vsync_i = !(v < VS);
                if (h >= HS + HB && h < HS + HB + HV && v >= VS + VB && v < VS + VB + VV)
                    {red_i, green_i, blue_i} = img[v - VS - VB][h - HS - HB];
                else
                    {red_i, green_i, blue_i} = 3'b000;
                if (v == rst_row && h == HT / 2)          rst = 1'b1;
                else if (v == rst_row && h == HT / 2 + 3) rst = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle(3);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL reset_locked: got %b want 0", locked);
        end
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, timing_err, frame_sum, sum_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pv=%b x=%0d y=%0d rgb=%b fs=%b te=%b sum=%h sv=%b want all 0",
                     pix_valid, pix_x, pix_y, pix_rgb, frame_start, timing_err, frame_sum, sum_valid);
        end
        @(posedge clk_main); #1;
        rst = 1'b0;
        drive_idle($urandom_range(3, 20));
    endtask

    task automatic test_lock();
        int t0, s0, f0, v0;
        t0 = terr_cnt;
        send_frame(VT, -1, 0, -1);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_first_vsync: locked=%b want 0", locked); end
        s0 = obs_q.size(); f0 = fs_cnt; v0 = sv_cnt;
        send_frame(VT, -1, 0, -1);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_second_vsync: locked=%b want 1", locked); end
        n_checks++;
        if (fs_cnt - f0 !== 1 || fs_pv !== 1'b1 || fs_pix !== {10'd0, 10'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL lock_frame_start: count=%0d pv=%b x=%0d y=%0d rgb=%b want 1 1 0 0 111",
                     fs_cnt - f0, fs_pv, fs_pix.x, fs_pix.y, fs_pix.rgb);
        end
        n_checks++;
        if (obs_q.size() - s0 !== NPIX) begin
            n_fail++; $display("FAIL lock_pix_count: got %0d want %0d", obs_q.size() - s0, NPIX);
        end
        n_checks++;
        if (terr_cnt - t0 !== 0) begin n_fail++; $display("FAIL lock_no_err: got %0d want 0", terr_cnt - t0); end
        n_checks++;
        if (sv_cnt - v0 !== int'(SUM_EN) || (SUM_EN ? last_sum : frame_sum) !== img_sum()) begin
            n_fail++;
            $display("FAIL lock_white_sum: pulses=%0d sum=%h want %0d %h",
                     sv_cnt - v0, SUM_EN ? last_sum : frame_sum, int'(SUM_EN), img_sum());
        end
    endtask

    task automatic test_locked_stream();
        int t0, s0, v0, e;
        pix_t lp;
        for (int f = 0; f < 4; f++) begin
            t0 = terr_cnt; s0 = obs_q.size(); v0 = sv_cnt;
            send_frame(VT, -1, (f == 1) ? 1 : 2, -1);
            @(negedge clk_main);
            n_checks++;
            if (obs_q.size() - s0 !== NPIX) begin
                n_fail++; $display("FAIL stream_count[%0d]: got %0d want %0d", f, obs_q.size() - s0, NPIX);
            end
            e = pix_errors(s0, NPIX);
            n_checks++;
            if (e !== 0) begin n_fail++; $display("FAIL stream_pixels[%0d]: %0d wrong want 0", f, e); end
            lp = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
            n_checks++;
            if (lp.x !== 10'(HV - 1) || lp.y !== 10'(VV - 1)) begin
                n_fail++; $display("FAIL stream_last[%0d]: got (%0d,%0d) want (%0d,%0d)", f, lp.x, lp.y, HV - 1, VV - 1);
            end
            n_checks++;
            if (locked !== 1'b1 || terr_cnt - t0 !== 0) begin
                n_fail++; $display("FAIL stream_lock[%0d]: locked=%b errs=%0d want 1 0", f, locked, terr_cnt - t0);
            end
            n_checks++;
            if (sv_cnt - v0 !== int'(SUM_EN) || (SUM_EN ? last_sum : frame_sum) !== img_sum()) begin
                n_fail++;
                $display("FAIL stream_sum[%0d]: pulses=%0d sum=%h want %0d %h",
                         f, sv_cnt - v0, SUM_EN ? last_sum : frame_sum, int'(SUM_EN), img_sum());
            end
        end
    endtask

    task automatic test_short_line();
        int t0, s0, v0, e;
        t0 = terr_cnt; s0 = obs_q.size(); v0 = sv_cnt;
        send_frame(VT, VS + VB + 5, 2, -1);
        @(negedge clk_main);
        n_checks++;
        if (terr_cnt - t0 !== 1 || terr_locked !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL short_line_err: pulses=%0d locked_at_pulse=%b locked=%b want 1 0 0",
                     terr_cnt - t0, terr_locked, locked);
        end
        e = pix_errors(s0, 6 * HV);
        n_checks++;
        if (obs_q.size() - s0 !== 6 * HV || e !== 0 || sv_cnt - v0 !== 0) begin
            n_fail++;
            $display("FAIL short_line_truncate: count=%0d bad=%0d sums=%0d want %0d 0 0",
                     obs_q.size() - s0, e, sv_cnt - v0, 6 * HV);
        end
        t0 = terr_cnt;
        send_frame(VT, -1, 2, -1);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL short_line_check: locked=%b want 0", locked); end
        s0 = obs_q.size();
        send_frame(VT, -1, 2, -1);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b1 || obs_q.size() - s0 !== NPIX || terr_cnt - t0 !== 0) begin
            n_fail++;
            $display("FAIL short_line_relock: locked=%b count=%0d errs=%0d want 1 %0d 0",
                     locked, obs_q.size() - s0, terr_cnt - t0, NPIX);
        end
    endtask

    task automatic test_short_frame();
        int t0, s0;
        rst = 1'b1;
        drive_idle(2);
        rst = 1'b0;
        drive_idle($urandom_range(2, 10));
        t0 = terr_cnt;
        send_frame(VT - 1, -1, 2, -1);
        send_frame(VT, -1, 2, -1);
        @(negedge clk_main);
        n_checks++;
        if (terr_cnt - t0 !== 1 || locked !== 1'b0) begin
            n_fail++; $display("FAIL short_frame_err: pulses=%0d locked=%b want 1 0", terr_cnt - t0, locked);
        end
        s0 = obs_q.size();
        send_frame(VT, -1, 2, -1);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b1 || obs_q.size() - s0 !== NPIX || terr_cnt - t0 !== 1) begin
            n_fail++;
            $display("FAIL short_frame_relock: locked=%b count=%0d errs=%0d want 1 %0d 1",
                     locked, obs_q.size() - s0, terr_cnt - t0, NPIX);
        end
    endtask

    task automatic test_reset_midframe();
        int t0, s0;
        fork
            send_frame(VT, -1, 2, VS + VB + 4);
            begin
                int n;
                n = 0;
                while (rst !== 1'b1 && n < 3 * VT * HT) begin
                    @(negedge clk_main);
                    n++;
                end
                n_checks++;
                if (rst !== 1'b1 ||
                    {pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, timing_err, frame_sum, sum_valid} !== '0) begin
                    n_fail++;
                    $display("FAIL midframe_reset_outputs: rst=%b pv=%b x=%0d y=%0d locked=%b te=%b sum=%h want rst=1 all 0",
                             rst, pix_valid, pix_x, pix_y, locked, timing_err, frame_sum);
                end
            end
        join
        t0 = terr_cnt;
        send_frame(VT, -1, 2, -1);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL midframe_check: locked=%b want 0", locked); end
        s0 = obs_q.size();
        send_frame(VT, -1, 0, -1);
        @(negedge clk_main);
        n_checks++;
        if (locked !== 1'b1 || obs_q.size() - s0 !== NPIX || terr_cnt - t0 !== 0) begin
            n_fail++;
            $display("FAIL midframe_relock: locked=%b count=%0d errs=%0d want 1 %0d 0",
                     locked, obs_q.size() - s0, terr_cnt - t0, NPIX);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_locked_stream();
        test_short_line();
        test_short_frame();
        test_reset_midframe();
        drive_idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
